// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control/status bundle between mode logic and the LED pattern engine
// Optional brightness input exists only when LED_PWM_EN is defined.
interface led_pattern_gen_if #(
  parameter int LED_W    = 8,
  parameter int PWM_BITS = 4
);
  logic [2:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic             load;
  logic [LED_W-1:0] pattern_in;
  logic [LED_W-1:0] led;
  logic             tick;
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] bright;

  modport master (output mode, speed, pause, load, pattern_in, bright, input led, tick);
  modport slave  (input mode, speed, pause, load, pattern_in, bright, output led, tick);
`else
  modport master (output mode, speed, pause, load, pattern_in, input led, tick);
  modport slave  (input mode, speed, pause, load, pattern_in, output led, tick);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - configurable LED pattern engine (static/rotate/bounce/blink/bar)
// Define LED_PWM_EN to add brightness gating through a free-running PWM counter.
module led_pattern_gen #(
  parameter int               LED_W      = 8,
  parameter int               CLK_FREQ   = 50000000,
  parameter int               STEP_HZ    = 10,
  parameter logic [LED_W-1:0] RESET_PAT  = LED_W'(8'b1110_0111),
  parameter bit               ACTIVE_LOW = 1'b0,
  parameter int               PWM_BITS   = 4
) (
  input logic              clk,
  input logic              rst_n,
  led_pattern_gen_if.slave bus
);
  localparam int BASE_PERIOD = CLK_FREQ / STEP_HZ;
  localparam int TW          = $clog2(BASE_PERIOD + 1);
  localparam int PW          = $clog2(LED_W);
  localparam int BW          = $clog2(LED_W + 1);

  localparam logic [2:0] M_STATIC = 3'd0;
  localparam logic [2:0] M_ROTL   = 3'd1;
  localparam logic [2:0] M_ROTR   = 3'd2;
  localparam logic [2:0] M_BOUNCE = 3'd3;
  localparam logic [2:0] M_BLINK  = 3'd4;
  localparam logic [2:0] M_BAR    = 3'd5;

  localparam logic [TW-1:0] BASE_P  = TW'(BASE_PERIOD);
  localparam logic [PW-1:0] POS_MAX = PW'(LED_W - 1);
  localparam logic [BW-1:0] BAR_MAX = BW'(LED_W);

  logic [TW-1:0]    timer_q, timer_d;
  logic [LED_W-1:0] base_q, base_d;
  logic [LED_W-1:0] work_q, work_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_down_q, dir_down_d;
  logic [BW-1:0]    bar_q, bar_d;
  logic             phase_q, phase_d;
  logic [2:0]       mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tick_q, tick_d;

  logic [TW-1:0]    shifted, period;
  logic             wrap, mode_chg;
  logic [LED_W-1:0] lit, gated;

  always_comb begin
    shifted = BASE_P >> bus.speed;
    period  = (shifted == '0) ? TW'(1) : shifted;
  end

  // >= rather than == so a speed-up with the timer already past the new end wraps at once
  assign wrap     = !bus.pause && (timer_q >= period - TW'(1));
  assign mode_chg = (bus.mode != mode_q);

  always_comb begin
    timer_d    = timer_q;
    base_d     = base_q;
    work_d     = work_q;
    pos_d      = pos_q;
    dir_down_d = dir_down_q;
    bar_d      = bar_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    if (bus.load || mode_chg) begin
      mode_d     = bus.mode;
      work_d     = bus.load ? bus.pattern_in : base_q;
      base_d     = bus.load ? bus.pattern_in : base_q;
      timer_d    = '0;
      pos_d      = '0;
      dir_down_d = 1'b0;
      bar_d      = '0;
      phase_d    = 1'b1;
    end else if (wrap) begin
      timer_d = '0;
      tick_d  = 1'b1;
      case (mode_q)
        M_ROTL: work_d = {work_q[LED_W-2:0], work_q[LED_W-1]};
        M_ROTR: work_d = {work_q[0], work_q[LED_W-1:1]};
        M_BOUNCE: begin
          // Turn around on the endpoint itself so neither end is shown twice
          if (!dir_down_q) begin
            if (pos_q == POS_MAX) begin
              dir_down_d = 1'b1;
              pos_d      = pos_q - PW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_down_d = 1'b0;
              pos_d      = PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        M_BLINK: phase_d = !phase_q;
        M_BAR:   bar_d   = (bar_q == BAR_MAX) ? '0 : bar_q + BW'(1);
        default: ;
      endcase
    end else if (!bus.pause) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Display is derived from next state so led lands on the same edge as the update
  always_comb begin
    lit = '0;
    case (mode_d)
      M_STATIC, M_ROTL, M_ROTR: lit = work_d;
      M_BOUNCE: lit[pos_d] = 1'b1;
      M_BLINK:  lit = phase_d ? base_d : '0;
      M_BAR: begin
        for (int i = 0; i < LED_W; i++) begin
          lit[i] = (i < int'(bar_d));
        end
      end
      default: lit = '0;
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign pwm_on    = (pwm_cnt_d < bus.bright) || (&bus.bright);
  assign gated     = lit & {LED_W{pwm_on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end
`else
  assign gated = lit;
`endif

  assign led_d = ACTIVE_LOW ? ~gated : gated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      base_q     <= RESET_PAT;
      work_q     <= RESET_PAT;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      bar_q      <= '0;
      phase_q    <= 1'b1;
      mode_q     <= M_STATIC;
      led_q      <= ACTIVE_LOW ? ~RESET_PAT : RESET_PAT;
      tick_q     <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      base_q     <= base_d;
      work_q     <= work_d;
      pos_q      <= pos_d;
      dir_down_q <= dir_down_d;
      bar_q      <= bar_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen (P=10, LED_W=8)
// A second ACTIVE_LOW instance shadows the first; LED_PWM_EN adds brightness cases.
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mark_cyc = 0;
  int   last_cyc = 0;
  logic [7:0] last_led = 8'h00;
  bit   mon_en = 1'b1;

  typedef struct {
    logic [7:0] led;
    logic       tick;
    int         gap;
  } ev_t;
  ev_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_pattern_gen_if #(.LED_W(8), .PWM_BITS(4)) bus1 ();
  led_pattern_gen_if #(.LED_W(8), .PWM_BITS(4)) bus2 ();

  assign bus2.mode       = bus1.mode;
  assign bus2.speed      = bus1.speed;
  assign bus2.pause      = bus1.pause;
  assign bus2.load       = bus1.load;
  assign bus2.pattern_in = bus1.pattern_in;
`ifdef LED_PWM_EN
  assign bus2.bright     = bus1.bright;
`endif

  led_pattern_gen #(.LED_W(8), .CLK_FREQ(100), .STEP_HZ(10), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  led_pattern_gen #(.LED_W(8), .CLK_FREQ(100), .STEP_HZ(10), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  task automatic push(input logic [7:0] l, input logic t, input int g);
    ev_t e;
    e.led  = l;
    e.tick = t;
    e.gap  = g;
    sb_q.push_back(e);
  endtask

  task automatic apply(input logic [2:0] m, input logic [1:0] s, input logic p,
                       input logic ld, input logic [7:0] pat, input int skip);
    repeat (skip) @(posedge clk);
    @(posedge clk);
    #1;
    bus1.mode       = m;
    bus1.speed      = s;
    bus1.pause      = p;
    bus1.load       = ld;
    bus1.pattern_in = pat;
    mark_cyc        = cyc;
    if (ld) begin
      @(posedge clk);
      #1;
      bus1.load = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Output event = tick or any led change; each one must match the head of the queue
  always @(negedge clk) begin
    n_chk++;
    if ({bus2.led, bus2.tick} !== {~bus1.led, bus1.tick}) begin
      n_fail++;
      $display("FAIL polarity got=%h/%b required=%h/%b", bus2.led, bus2.tick, ~bus1.led, bus1.tick);
    end
    if (rst_n && mon_en && (bus1.tick === 1'b1 || bus1.led !== last_led)) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event got led=%h tick=%b required none", bus1.led, bus1.tick);
      end else begin
        ev_t e;
        int  ref_c;
        e = sb_q.pop_front();
        ref_c = (mark_cyc > last_cyc) ? mark_cyc : last_cyc;
        n_chk++;
        if (bus1.led !== e.led || bus1.tick !== e.tick) begin
          n_fail++;
          $display("FAIL event got led=%h tick=%b required led=%h tick=%b", bus1.led, bus1.tick, e.led, e.tick);
        end
        if (e.gap != 0) begin
          n_chk++;
          if (cyc - ref_c != e.gap) begin
            n_fail++;
            $display("FAIL event_gap led=%h got=%0d required=%0d", e.led, cyc - ref_c, e.gap);
          end
        end
      end
      last_cyc = cyc;
    end
    last_led = bus1.led;
  end

`ifdef LED_PWM_EN
  task automatic pwm_case(input logic [3:0] br, input int exp_hi);
    int hi = 0;
    int bad = 0;
    bus1.bright = br;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus1.led == 8'hFF) hi++;
      else if (bus1.led != 8'h00) bad++;
    end
    n_chk++;
    if (hi != exp_hi || bad != 0) begin
      n_fail++;
      $display("FAIL pwm_bright%0d got hi=%0d odd=%0d required hi=%0d odd=0", br, hi, bad, exp_hi);
    end
  endtask
`endif

  logic [7:0] bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] bar_seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

  initial begin
    bus1.mode       = 3'd0;
    bus1.speed      = 2'd0;
    bus1.pause      = 1'b0;
    bus1.load       = 1'b0;
    bus1.pattern_in = 8'h00;
`ifdef LED_PWM_EN
    bus1.bright     = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (bus1.led !== 8'hE7 || bus1.tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got led=%h tick=%b required led=e7 tick=0", bus1.led, bus1.tick);
    end
    rst_n    = 1'b1;
    mark_cyc = cyc;
    push(8'hE7, 1'b1, 10);
    drain(40);

    apply(3'd1, 2'd0, 1'b0, 1'b0, 8'h00, 0);
    push(8'hCF, 1'b1, 11);
    push(8'h9F, 1'b1, 10);
    push(8'h3F, 1'b1, 10);
    drain(60);

    apply(3'd1, 2'd1, 1'b0, 1'b0, 8'h00, 0);
    push(8'h7E, 1'b1, 4);
    push(8'hFC, 1'b1, 5);
    drain(30);

    apply(3'd1, 2'd1, 1'b1, 1'b0, 8'h00, 0);
    repeat (30) @(posedge clk);
    #1;
    n_chk++;
    if (bus1.led !== 8'hFC || bus1.tick !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_hold got led=%h tick=%b required led=fc tick=0", bus1.led, bus1.tick);
    end
    apply(3'd1, 2'd1, 1'b0, 1'b0, 8'h00, 0);
    push(8'hF9, 1'b1, 4);
    drain(20);

    apply(3'd3, 2'd0, 1'b0, 1'b0, 8'h00, 0);
    push(8'h01, 1'b0, 1);
    foreach (bounce_seq[i]) push(bounce_seq[i], 1'b1, 10);
    drain(200);

    // Land load + mode change on the very edge the timer would wrap
    apply(3'd4, 2'd0, 1'b0, 1'b1, 8'hA5, 8);
    push(8'hA5, 1'b0, 1);
    push(8'h00, 1'b1, 10);
    push(8'hA5, 1'b1, 10);
    drain(60);

    apply(3'd5, 2'd0, 1'b0, 1'b0, 8'h00, 0);
    push(8'h00, 1'b0, 1);
    foreach (bar_seq[i]) push(bar_seq[i], 1'b1, 10);
    drain(150);

    apply(3'd6, 2'd0, 1'b0, 1'b0, 8'h00, 0);
    push(8'h00, 1'b1, 11);
    push(8'h00, 1'b1, 10);
    push(8'h00, 1'b1, 10);
    drain(60);

`ifdef LED_PWM_EN
    mon_en = 1'b0;
    apply(3'd0, 2'd0, 1'b0, 1'b1, 8'hFF, 0);
    pwm_case(4'd4, 8);
    pwm_case(4'd15, 32);
    pwm_case(4'd0, 0);
`endif

    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=cycle %0d required=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine driving an LED_W-bit bank from one clock. It replaces the fixed 4-mode LED controller with a configurable engine:
- modes: static, rotate left, rotate right, bounce, blink, bar fill
- runtime speed select, pause and pattern load
- selectable output polarity
It sits between the top-level mode/state logic and the board LED pins.

Parameters:
LED_W, 8, number of LEDs (≥2)
CLK_FREQ, 50000000, clock frequency in Hz
STEP_HZ, 10, base step rate; BASE_PERIOD = CLK_FREQ/STEP_HZ cycles
RESET_PAT, 8'b1110_0111 (LED_W bits), base/working pattern after reset
ACTIVE_LOW, 0, 1 = invert led output (lit = 0)
PWM_BITS, 4, brightness resolution (used only with LED_PWM_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  3  0 static, 1 rot-left, 2 rot-right, 3 bounce, 4 blink, 5 bar, 6/7 all-off
speed  in  2  step period = max(1, BASE_PERIOD >> speed)
pause  in  1  1 = freeze timer and state; led holds
load  in  1  1-cycle pulse: capture pattern_in
pattern_in  in  LED_W  pattern to load
led  out  LED_W  registered LED drive (polarity per ACTIVE_LOW)
tick  out  1  1-cycle pulse, high in the first cycle a stepped led value is shown

Behaviour:
- Reset (async, rst_n=0):
  - timer=0, base=work=RESET_PAT, pos=0, dir=up, bar=0, phase=1, mode_q=0, tick=0
  - led=RESET_PAT (inverted if ACTIVE_LOW)
- Timer:
  - counts 0..P-1, where P = max(1, BASE_PERIOD>>speed).
  - Wrap condition: timer ≥ P-1 and pause=0. On wrap, timer→0 and state steps on the same edge.
  - A speed change to a shorter P with timer already past P-1 wraps on the next cycle.
- pause=1: timer, state, led and phase all hold; tick=0.
- Priority per edge, highest first:
  1. load
  2. mode change (mode≠mode_q)
  3. step
  4. hold
- load: base=work=pattern_in; timer=0; pos=0; dir=up; bar=0; phase=1; no step that cycle.
- Mode change: mode_q=mode; reinit exactly as load but with work=base; timer=0. No tick.
- Step actions per mode:
  - 0 static: work unchanged; tick still pulses.
  - 1: work = {work[LED_W-2:0], work[LED_W-1]}.
  - 2: work = {work[0], work[LED_W-1:1]}.
  - 3 bounce: one lit LED at pos. pos increments while dir=up; at LED_W-1 dir→down; at 0 dir→up. Endpoints are not repeated, so LED_W=8 gives pos sequence 0,1..7,6..0,1.
  - 4 blink: phase toggles; lit = phase ? base : 0.
  - 5 bar: bar = (bar==LED_W) ? 0 : bar+1; lit = low `bar` bits set.
  - 6/7: lit = 0; timer still runs; tick pulses.
- Output:
  - lit vector is computed from the post-edge state, and led is registered on the same edge as the state update. Latency from step, load or mode change to led is 1 edge.
  - led = ACTIVE_LOW ? ~lit : lit.
- tick is registered, high exactly one cycle per step, and never on load, mode change or reset.
- Width rules:
  - timer width is $clog2(BASE_PERIOD+1).
  - pos width is $clog2(LED_W).
  - bar width is $clog2(LED_W+1).

Optional Feature:
LED_PWM_EN
- Defined:
  - adds input bright [PWM_BITS-1:0] and a free-running PWM_BITS counter pwm_cnt (reset 0, increments every cycle, wraps).
  - lit bits are gated: on when pwm_cnt < bright, or when bright is all-ones (100%).
  - bright=0 gives all LEDs off.
  - Gating is applied before the polarity inversion, and led stays registered.
- Undefined: no bright port, no counter; lit drives led ungated.

Test Plan:
- Setup for all cases: CLK_FREQ=100, STEP_HZ=10 (P=10), LED_W=8, ACTIVE_LOW=0.
- Reset: hold rst_n=0 then release, mode=0 → led=8'hE7, tick=0; after 10 cycles tick pulses once and led stays 8'hE7.
- Rotate/speed: mode=1, speed=0 → E7→CF→9F→3F at 10-cycle spacing; set speed=1 → spacing becomes 5 cycles; pause=1 for 30 cycles → led and tick frozen.
- Bounce: mode=3 → led 01,02,..,80,40,..,01,02; each step coincides with tick; no repeated 80 or 01.
- Load/mode priority: assert load (pattern_in=8'hA5) in the same cycle as a mode change and a timer wrap → next led=A5 (mode_q updated), no tick, timer restarts at 0. Then mode=4 → A5,00,A5 every 10 cycles.
- Bar wrap and reserved modes: mode=5 → 00,01,03,..,FF,00. mode=6 → led=00 while tick keeps pulsing. With ACTIVE_LOW=1 every value is inverted (e.g. bar FF→00).
- LED_PWM_EN: mode=0, base=FF, bright=4 → each LED high exactly 4 of every 16 cycles; bright=15 → constant FF; bright=0 → constant 00.
